// File: rtl/cluster_rsp_buf_pkg.sv
// cluster_rsp_buf_pkg: field widths and buffered entry layout for the cluster response buffer
// Widths come from the shared define.v macros; the fallbacks below apply only when
// define.v has not been compiled ahead of this file.
`ifndef OP_BITS
`define OP_BITS 4
`endif
`ifndef D_SOURCE
`define D_SOURCE 4
`endif
`ifndef SOURCE_BITS
`define SOURCE_BITS 6
`endif
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 32
`endif
`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif
`ifndef DCACHE_BLOCKWORDS
`define DCACHE_BLOCKWORDS 2
`endif
`ifndef DATA_BITS
`define DATA_BITS 64
`endif
`ifndef NUM_SM_IN_CLUSTER
`define NUM_SM_IN_CLUSTER 2
`endif
`ifndef NUM_CLUSTER_DEPTH
`define NUM_CLUSTER_DEPTH 1
`endif

package cluster_rsp_buf_pkg;
    localparam int OP_W   = `OP_BITS;
    localparam int SRC_W  = `SOURCE_BITS;
    localparam int LSRC_W = `D_SOURCE;
    localparam int ADDR_W = `ADDRESS_BITS;
    localparam int DATA_W = `DATA_BITS;
    localparam int WORD_W = `WORDLENGTH;
    localparam int LINE_W = `DCACHE_BLOCKWORDS * `WORDLENGTH;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic [LSRC_W-1:0] source;
    } rsp_entry_t;
endpackage

// File: rtl/rsp_sync_fifo.sv
// rsp_sync_fifo: single-clock FIFO with registered head, no bypass
// Ports: clk/rst (sync, active-high); push/wdata write the tail when not full;
// pop removes the head when not empty; rdata shows the head; full/empty/count report fill level.
module rsp_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    always_comb begin
        full    = count == CW'(DEPTH);
        empty   = count == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/cluster_rsp_buf.sv
// cluster_rsp_buf: routes L2 responses into per-SM FIFOs so a stalled SM cannot block the others
// Ports: rsp_in_* is the L2 response handshake (source MSBs select the SM);
// rsp_out_* are per-SM handshakes carrying the head entry with the SM index stripped;
// occupancy_o gives each FIFO's count; route_err_o is a sticky flag for out-of-range SM indices.
module cluster_rsp_buf
    import cluster_rsp_buf_pkg::*;
#(
    parameter int NUM_SM = `NUM_SM_IN_CLUSTER,
    parameter int IDX_W  = `NUM_CLUSTER_DEPTH,
    parameter int DEPTH  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   rsp_in_valid_i,
    output logic                                   rsp_in_ready_o,
    input  logic [OP_W-1:0]                        rsp_in_opcode_i,
    input  logic [SRC_W-1:0]                       rsp_in_source_i,
    input  logic [ADDR_W-1:0]                      rsp_in_address_i,
    input  logic [DATA_W-1:0]                      rsp_in_data_i,
    output logic [NUM_SM-1:0]                      rsp_out_valid_o,
    input  logic [NUM_SM-1:0]                      rsp_out_ready_i,
    output logic [NUM_SM*3-1:0]                    rsp_out_opcode_o,
    output logic [NUM_SM*WORD_W-1:0]               rsp_out_addr_o,
    output logic [NUM_SM*LINE_W-1:0]               rsp_out_data_o,
    output logic [NUM_SM*LSRC_W-1:0]               rsp_out_source_o,
    output logic [NUM_SM*$clog2(DEPTH+1)-1:0]      occupancy_o,
    output logic                                   route_err_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic [IDX_W-1:0]  t;
    logic              in_range;
    logic [NUM_SM-1:0] hit, full, empty;
    rsp_entry_t        wr_entry;
    rsp_entry_t        head [NUM_SM];
    logic              unused_src;

    assign unused_src = ^rsp_in_source_i;

    always_comb begin
        t        = NUM_SM == 1 ? '0 : rsp_in_source_i[SRC_W-1 -: IDX_W];
        in_range = 32'(t) < 32'(NUM_SM);
        // out-of-range beats are always consumed so a bad source cannot wedge the L2 channel
        rsp_in_ready_o = in_range ? ~|(hit & full) : 1'b1;
        wr_entry = '{opcode: rsp_in_opcode_i, address: rsp_in_address_i,
                     data: rsp_in_data_i, source: rsp_in_source_i[LSRC_W-1:0]};
    end

    always_ff @(posedge clk)
        if (rst) route_err_o <= 1'b0;
        else if (rsp_in_valid_i && !in_range) route_err_o <= 1'b1;

    for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
        logic unused_op;
        assign hit[i] = t == IDX_W'(i);
        rsp_sync_fifo #(.DATA_WIDTH($bits(rsp_entry_t)), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (rsp_in_valid_i && rsp_in_ready_o && hit[i]),
            .pop   (rsp_out_ready_i[i]),
            .wdata (wr_entry),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (occupancy_o[i*CW +: CW])
        );
        assign unused_op                            = ^head[i].opcode;
        assign rsp_out_valid_o[i]                   = !empty[i];
        assign rsp_out_opcode_o[i*3 +: 3]           = head[i].opcode[2:0];
        assign rsp_out_addr_o[i*WORD_W +: WORD_W]   = WORD_W'(head[i].address);
        assign rsp_out_data_o[i*LINE_W +: LINE_W]   = LINE_W'(head[i].data);
        assign rsp_out_source_o[i*LSRC_W +: LSRC_W] = head[i].source;
    end
endmodule
